// File: rtl/clk_rst_sequencer.sv
// Power-up/recovery sequencer: PLL reset, lock qualification, DDR3 reset release, calibration wait.
// Optional macro CLK_RST_SEQ_SW_RESET_EN adds sw_rst_req to restart the sequence or leave FAIL.
//
// state            | meaning
// RST_PLL     (0)  | clock wizard held in reset for PLL_RST_CYCLES
// WAIT_LOCK   (1)  | waiting for synced locked, bounded by LOCK_TIMEOUT
// LOCK_STABLE (2)  | locked must stay high LOCK_STABLE consecutive cycles
// RELEASE_MIG (3)  | single cycle, DDR3 controller reset released
// WAIT_CALIB  (4)  | waiting for calibration, bounded by CALIB_TIMEOUT
// RUN         (5)  | all resets released
// FAIL        (6)  | retries exhausted, everything held in reset

module clk_rst_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_STABLE    = 64,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int CALIB_TIMEOUT  = 1048576,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       calib_done,
`ifdef CLK_RST_SEQ_SW_RESET_EN
  input  logic       sw_rst_req,
`endif
  output logic       pll_rst,
  output logic       mig_rst,
  output logic       core_rst,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt,
  output logic       fail
);

  localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
  localparam int CNT_MAX_B = (LOCK_TIMEOUT > CALIB_TIMEOUT) ? LOCK_TIMEOUT : CALIB_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_TIMEOUT - 1);

  localparam logic [2:0] ST_RST_PLL     = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK   = 3'd1;
  localparam logic [2:0] ST_LOCK_STABLE = 3'd2;
  localparam logic [2:0] ST_RELEASE_MIG = 3'd3;
  localparam logic [2:0] ST_WAIT_CALIB  = 3'd4;
  localparam logic [2:0] ST_RUN         = 3'd5;
  localparam logic [2:0] ST_FAIL        = 3'd6;

  logic             lk_meta, lk, cd_meta, cd;
  logic             sw_req;
  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       retry_nxt;
  logic             fail_nxt;
  logic             attempt_fail;
  logic [2:0]       rst_nxt;

`ifdef CLK_RST_SEQ_SW_RESET_EN
  assign sw_req = sw_rst_req;
`else
  assign sw_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
      cd_meta <= 1'b0;
      cd      <= 1'b0;
    end else begin
      lk_meta <= locked;
      lk      <= lk_meta;
      cd_meta <= calib_done;
      cd      <= cd_meta;
    end
  end

  // Loss of lock is checked first everywhere so it wins over cd, sw requests and timeouts.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + CNT_W'(1);
    retry_nxt    = retry_cnt;
    fail_nxt     = fail;
    attempt_fail = 1'b0;
    case (state)
      ST_RST_PLL: begin
        if (cnt == PLL_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lk)                     state_nxt = ST_LOCK_STABLE;
        else if (cnt == LOCK_LAST)  attempt_fail = 1'b1;
      end
      ST_LOCK_STABLE: begin
        if (!lk)                      state_nxt = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = ST_RELEASE_MIG;
      end
      ST_RELEASE_MIG: begin
        state_nxt = lk ? ST_WAIT_CALIB : ST_RST_PLL;
      end
      ST_WAIT_CALIB: begin
        if (!lk || sw_req)          state_nxt = ST_RST_PLL;
        else if (cd)                state_nxt = ST_RUN;
        else if (cnt == CALIB_LAST) attempt_fail = 1'b1;
      end
      ST_RUN: begin
        cnt_nxt = cnt;
        if (!lk || sw_req) state_nxt = ST_RST_PLL;
        else if (!cd)      state_nxt = ST_WAIT_CALIB;
      end
      ST_FAIL: begin
        cnt_nxt = cnt;
        if (sw_req) begin
          state_nxt = ST_RST_PLL;
          retry_nxt = 2'd0;
          fail_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_RST_PLL;
    endcase

    if (attempt_fail) begin
      if (int'(retry_cnt) < MAX_RETRIES) begin
        state_nxt = ST_RST_PLL;
        retry_nxt = (retry_cnt == 2'b11) ? retry_cnt : retry_cnt + 2'd1;
      end else begin
        state_nxt = ST_FAIL;
        fail_nxt  = 1'b1;
      end
    end

    if (state_nxt != state) cnt_nxt = '0;
  end

  // Reset outputs decoded from the next state so they are registered yet aligned with seq_state.
  always_comb begin
    rst_nxt = 3'b111;
    case (state_nxt)
      ST_WAIT_LOCK, ST_LOCK_STABLE: rst_nxt = 3'b011;
      ST_RELEASE_MIG, ST_WAIT_CALIB: rst_nxt = 3'b001;
      ST_RUN:                        rst_nxt = 3'b000;
      default:                       rst_nxt = 3'b111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RST_PLL;
      cnt       <= '0;
      retry_cnt <= 2'd0;
      fail      <= 1'b0;
      pll_rst   <= 1'b1;
      mig_rst   <= 1'b1;
      core_rst  <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      fail      <= fail_nxt;
      {pll_rst, mig_rst, core_rst} <= rst_nxt;
    end
  end

  assign seq_state = state;

  a_reset_order: assert property (@(posedge clk) disable iff (reset)
    (core_rst || (!mig_rst && !pll_rst)) && (mig_rst || !pll_rst));

endmodule
